// File: rtl/alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : alu_exec_ctrl
// Brief   : Multi-cycle execute sequencer in front of the 8-bit ALU: 4x8
//           register file, operand drive, writeback and Z/N/C/V flags.
//           Option macro ALU_EXEC_FAST_WB_EN merges EXEC and WB.
// Revision: 1.0 - initial release
// ============================================================================
module alu_exec_ctrl #(
    parameter logic [7:0] REG_RST  = 8'h00,
    parameter logic [3:0] FLAG_RST = 4'b0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [17:0] instr,
    output logic [7:0]  alu_operand_a,
    output logic [7:0]  alu_operand_b,
    output logic [3:0]  alu_op,
    input  logic [7:0]  alu_result,
    input  logic        alu_cout,
    input  logic        alu_overflow,
    output logic [3:0]  flags,
    output logic        done,
    output logic        illegal,
    input  logic [1:0]  dbg_sel,
    output logic [7:0]  dbg_data
);

    // Opcode values mirror the shared ALU opcode header
    localparam logic [3:0] c_OP_ADD = 4'h0;
    localparam logic [3:0] c_OP_SUB = 4'h1;
    localparam logic [3:0] c_OP_AND = 4'h2;
    localparam logic [3:0] c_OP_OR  = 4'h3;
    localparam logic [3:0] c_OP_XOR = 4'h4;

`ifdef ALU_EXEC_FAST_WB_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;
`endif

    state_t      r_state;
    logic        r_ready;
    logic [17:0] r_instr;
    logic [7:0]  r_regs [4];
    logic [7:0]  r_op_a;
    logic [7:0]  r_op_b;
    logic [3:0]  r_alu_op;
    logic [3:0]  r_flags;
    logic        r_done;
    logic        r_illegal;

    logic        w_is_ldi;
    logic        w_use_imm;
    logic [3:0]  w_op;
    logic [1:0]  w_rd;
    logic [1:0]  w_rs;
    logic [7:0]  w_imm;
    logic [7:0]  w_res;
    logic        w_cout;
    logic        w_ovf;
    logic        w_sub_v;
    logic        w_zero;
    logic        w_supported;
    logic        w_wr_en;
    logic [7:0]  w_wr_data;
    logic [3:0]  w_flags_nxt;

    assign w_is_ldi  = r_instr[17];
    assign w_use_imm = r_instr[16];
    assign w_op      = r_instr[15:12];
    assign w_rd      = r_instr[11:10];
    assign w_rs      = r_instr[9:8];
    assign w_imm     = r_instr[7:0];

`ifdef ALU_EXEC_FAST_WB_EN
    // Writeback samples the ALU directly on the same edge
    assign w_res  = alu_result;
    assign w_cout = alu_cout;
    assign w_ovf  = alu_overflow;
`else
    logic [7:0] r_res;
    logic       r_cout;
    logic       r_ovf;

    assign w_res  = r_res;
    assign w_cout = r_cout;
    assign w_ovf  = r_ovf;
`endif

    // ALU overflow is an addition term; subtraction overflow is rebuilt here
    assign w_sub_v = (r_op_a[7] != r_op_b[7]) & (w_res[7] != r_op_a[7]);
    assign w_zero  = (w_res == 8'h00);

    always_comb begin
        w_supported = 1'b0;
        w_flags_nxt = r_flags;
        if (!w_is_ldi) begin
            case (w_op)
                c_OP_ADD: begin
                    w_supported = 1'b1;
                    w_flags_nxt = {w_zero, w_res[7], w_cout, w_ovf};
                end
                c_OP_SUB: begin
                    w_supported = 1'b1;
                    w_flags_nxt = {w_zero, w_res[7], w_cout, w_sub_v};
                end
                c_OP_AND, c_OP_OR, c_OP_XOR: begin
                    w_supported = 1'b1;
                    w_flags_nxt = {w_zero, w_res[7], 2'b00};
                end
                default: ;
            endcase
        end
    end

    assign w_wr_en   = w_is_ldi | w_supported;
    assign w_wr_data = w_is_ldi ? w_imm : w_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b0;
            r_instr   <= '0;
            r_op_a    <= 8'h00;
            r_op_b    <= 8'h00;
            r_alu_op  <= c_OP_ADD;
            r_flags   <= FLAG_RST;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= REG_RST;
            end
`ifndef ALU_EXEC_FAST_WB_EN
            r_res     <= 8'h00;
            r_cout    <= 1'b0;
            r_ovf     <= 1'b0;
`endif
        end else begin
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    if (instr_valid && r_ready) begin
                        r_instr <= instr;
                        r_ready <= 1'b0;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_op_a   <= r_regs[w_rd];
                    r_op_b   <= w_use_imm ? w_imm : r_regs[w_rs];
                    r_alu_op <= w_op;
                    r_state  <= S_EXEC;
`ifdef ALU_EXEC_FAST_WB_EN
                    r_done    <= 1'b1;
                    r_illegal <= ~w_wr_en;
`endif
                end
`ifdef ALU_EXEC_FAST_WB_EN
                S_EXEC: begin
                    if (w_wr_en) begin
                        r_regs[w_rd] <= w_wr_data;
                    end
                    r_flags <= w_flags_nxt;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
`else
                S_EXEC: begin
                    r_res     <= alu_result;
                    r_cout    <= alu_cout;
                    r_ovf     <= alu_overflow;
                    r_done    <= 1'b1;
                    r_illegal <= ~w_wr_en;
                    r_state   <= S_WB;
                end
                S_WB: begin
                    if (w_wr_en) begin
                        r_regs[w_rd] <= w_wr_data;
                    end
                    r_flags <= w_flags_nxt;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign instr_ready   = r_ready;
    assign alu_operand_a = r_op_a;
    assign alu_operand_b = r_op_b;
    assign alu_op        = r_alu_op;
    assign flags         = r_flags;
    assign done          = r_done;
    assign illegal       = r_illegal;
    assign dbg_data      = r_regs[dbg_sel];

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_exec_ctrl
// Brief   : Scoreboard bench for alu_exec_ctrl with a behavioural ALU model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_exec_ctrl;

    localparam logic [3:0] c_ADD = 4'h0;
    localparam logic [3:0] c_SUB = 4'h1;
    localparam logic [3:0] c_AND = 4'h2;
    localparam logic [3:0] c_OR  = 4'h3;
    localparam logic [3:0] c_XOR = 4'h4;
    localparam logic [3:0] c_BAD = 4'hF;

`ifdef ALU_EXEC_FAST_WB_EN
    localparam int c_LAT = 1;
`else
    localparam int c_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [17:0] instr;
    logic [7:0]  alu_operand_a;
    logic [7:0]  alu_operand_b;
    logic [3:0]  alu_op;
    logic [7:0]  alu_result;
    logic        alu_cout;
    logic        alu_overflow;
    logic [3:0]  flags;
    logic        done;
    logic        illegal;
    logic [1:0]  dbg_sel;
    logic [7:0]  dbg_data;

    logic [1:0]  stim_sel = 2'd0;
    logic [1:0]  mon_sel  = 2'd0;
    logic        mon_active = 1'b0;
    assign dbg_sel = mon_active ? mon_sel : stim_sel;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [1:0] rd;
        logic [7:0] val;
        logic [3:0] flg;
        logic       ill;
        int         acc;
    } exp_t;
    exp_t sb_q[$];

    alu_exec_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .alu_operand_a(alu_operand_a),
        .alu_operand_b(alu_operand_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_cout     (alu_cout),
        .alu_overflow (alu_overflow),
        .flags        (flags),
        .done         (done),
        .illegal      (illegal),
        .dbg_sel      (dbg_sel),
        .dbg_data     (dbg_data)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // ALU model: overflow is the addition term for every op; logic ops leave
    // cout/overflow at stale 1s so the sequencer must not pass them through.
    logic [8:0] m_sum;
    logic [8:0] m_dif;
    always_comb begin
        m_sum        = {1'b0, alu_operand_a} + {1'b0, alu_operand_b};
        m_dif        = {1'b0, alu_operand_a} + {1'b0, ~alu_operand_b} + 9'd1;
        alu_result   = 8'hA5;
        alu_cout     = 1'b1;
        alu_overflow = 1'b1;
        case (alu_op)
            c_ADD: begin
                alu_result   = m_sum[7:0];
                alu_cout     = m_sum[8];
                alu_overflow = (alu_operand_a[7] == alu_operand_b[7]) && (m_sum[7] != alu_operand_a[7]);
            end
            c_SUB: begin
                alu_result   = m_dif[7:0];
                alu_cout     = m_dif[8];
                alu_overflow = (alu_operand_a[7] == alu_operand_b[7]) && (m_sum[7] != alu_operand_a[7]);
            end
            c_AND:   alu_result = alu_operand_a & alu_operand_b;
            c_OR:    alu_result = alu_operand_a | alu_operand_b;
            c_XOR:   alu_result = alu_operand_a ^ alu_operand_b;
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] enc(input logic ldi, input logic imm_f, input logic [3:0] op,
                                        input logic [1:0] rd, input logic [1:0] rs, input logic [7:0] imm);
        return {ldi, imm_f, op, rd, rs, imm};
    endfunction

    // Issue one instruction and push its expected writeback; optionally keep
    // instr_valid asserted until the sequencer is back in IDLE.
    task automatic issue(input logic [17:0] ins, input logic [7:0] exp_val,
                         input logic [3:0] exp_flg, input logic exp_ill, input bit hold);
        exp_t e;
        int   n;
        @(negedge clk);
        instr       = ins;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            instr_valid = 1'b0;
        end else begin
            e.rd  = ins[11:10];
            e.val = exp_val;
            e.flg = exp_flg;
            e.ill = exp_ill;
            e.acc = cyc + 1;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            if (hold) begin
                for (int k = 0; k < c_LAT + 1; k++) begin
                    @(negedge clk);
                    chk("ready_while_busy", {31'd0, instr_ready}, 32'd0);
                end
            end
            instr_valid = 1'b0;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!instr_ready && n < 20);
            if (!instr_ready) chk("complete_timeout", 32'd0, 32'd1);
        end
    endtask

    // Monitor: pop on every done pulse and check the committed state
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && illegal && !done) begin
                checks++;
                failures++;
                $display("FAIL illegal_without_done: got illegal=1 done=0 expected done=1");
            end
            if (rst_n && done) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done=1 expected no pending instruction");
                end else begin
                    e = sb_q.pop_front();
                    chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
                    chk("latency", cyc - e.acc, c_LAT);
                    mon_sel    = e.rd;
                    mon_active = 1'b1;
                    @(posedge clk);
                    #1;
                    chk("reg_value", {24'd0, dbg_data}, {24'd0, e.val});
                    chk("flags", {28'd0, flags}, {28'd0, e.flg});
                    chk("done_pulse", {31'd0, done}, 32'd0);
                    chk("illegal_pulse", {31'd0, illegal}, 32'd0);
                    mon_active = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        #1;
        chk("rst_ready", {31'd0, instr_ready}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_op_a", {24'd0, alu_operand_a}, 32'd0);
        chk("rst_op_b", {24'd0, alu_operand_b}, 32'd0);
        chk("rst_alu_op", {28'd0, alu_op}, {28'd0, c_ADD});
        chk("rst_flags", {28'd0, flags}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            stim_sel = i[1:0];
            #1;
            chk("rst_reg", {24'd0, dbg_data}, 32'd0);
        end
        repeat (3) @(negedge clk);
        chk("ready_in_reset", {31'd0, instr_ready}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_after_reset", {31'd0, instr_ready}, 32'd1);

        //         ins                                          reg    flags ZNCV  ill hold
        issue(enc(1, 1, c_ADD, 2'd1, 2'd0, 8'h7F),               8'h7F, 4'b0000, 0, 0);
        issue(enc(1, 1, c_ADD, 2'd2, 2'd0, 8'h01),               8'h01, 4'b0000, 0, 0);
        issue(enc(0, 0, c_ADD, 2'd1, 2'd2, 8'h00),               8'h80, 4'b0101, 0, 0);
        issue(enc(1, 1, c_ADD, 2'd0, 2'd0, 8'h80),               8'h80, 4'b0101, 0, 0);
        issue(enc(0, 1, c_SUB, 2'd0, 2'd0, 8'h01),               8'h7F, 4'b0011, 0, 0);
        issue(enc(0, 1, c_ADD, 2'd2, 2'd0, 8'hFF),               8'h00, 4'b1010, 0, 0);
        issue(enc(1, 1, c_ADD, 2'd3, 2'd0, 8'h0F),               8'h0F, 4'b1010, 0, 0);
        issue(enc(0, 1, c_XOR, 2'd3, 2'd0, 8'h0F),               8'h00, 4'b1000, 0, 0);
        issue(enc(0, 0, c_BAD, 2'd1, 2'd2, 8'h00),               8'h80, 4'b1000, 1, 0);
        issue(enc(0, 0, c_ADD, 2'd0, 2'd0, 8'h00),               8'hFE, 4'b0101, 0, 0);
        issue(enc(0, 1, c_AND, 2'd1, 2'd0, 8'hC0),               8'h80, 4'b0100, 0, 0);
        issue(enc(0, 1, c_OR,  2'd2, 2'd0, 8'h3C),               8'h3C, 4'b0000, 0, 1);

        // Abort an instruction with reset while it is in EXEC
        @(negedge clk);
        instr       = enc(0, 1, c_ADD, 2'd3, 2'd0, 8'h01);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'd0, instr_ready}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_flags", {28'd0, flags}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            stim_sel = i[1:0];
            #1;
            chk("abort_reg", {24'd0, dbg_data}, 32'd0);
        end

        issue(enc(1, 1, c_ADD, 2'd2, 2'd0, 8'h5A),               8'h5A, 4'b0000, 0, 0);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
- Multi-cycle execute sequencer that sits directly upstream of the 8-bit ALU in the CPU.
- Accepts one decoded instruction at a time over a valid/ready handshake and holds a 4-entry x 8-bit register file.
- Drives the ALU operands and alu_op, then captures the ALU result, carry and overflow.
- Writes the result back to the register file and maintains the Z/N/C/V flag register.

Parameters:
- REG_RST, 8'h00, reset value of every register-file entry.
- FLAG_RST, 4'b0000, reset value of flags {Z,N,C,V}.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  sequencer can accept an instruction
- instr  in  18  [17] is_ldi, [16] use_imm, [15:12] alu_op, [11:10] rd, [9:8] rs, [7:0] imm
- alu_operand_a  out  8  to ALU operand_a
- alu_operand_b  out  8  to ALU operand_b
- alu_op  out  4  to ALU alu_op; codes from header/opcodes.vh
- alu_result  in  8  from ALU result
- alu_cout  in  1  from ALU cout
- alu_overflow  in  1  from ALU overflow
- flags  out  4  {Z,N,C,V}
- done  out  1  one-cycle pulse at writeback
- illegal  out  1  one-cycle pulse when an unsupported alu_op is retired
- dbg_sel  in  2  register-file read select
- dbg_data  out  8  combinational read of reg[dbg_sel]

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; all registers = REG_RST; flags = FLAG_RST.
  - alu_operand_a/b = 0; alu_op = `ADD; done = illegal = 0; instr_ready = 0 while rst_n is low.
- FSM states: IDLE, DECODE, EXEC, WB.
- instr_ready = 1 only in IDLE.
- Transfer occurs on a clk edge with instr_valid & instr_ready; the instruction is latched and the FSM goes IDLE->DECODE.
- instr_valid is ignored outside IDLE; no buffering.
- DECODE (registered outputs update at end of this cycle):
  - alu_operand_a = reg[rd].
  - alu_operand_b = use_imm ? imm : reg[rs].
  - alu_op = instr[15:12].
  - Next state: EXEC.
- EXEC: the ALU is combinational; latch alu_result, alu_cout and alu_overflow into internal regs. Next state: WB.
- WB, non-LDI supported op (`ADD, `SUB, `AND, `OR, `XOR):
  - reg[rd] = result; done = 1; next state IDLE.
  - Z = (result == 0); N = result[7].
  - ADD: C = alu_cout; V = alu_overflow.
  - SUB: C = alu_cout; V recomputed locally as (a[7] != b[7]) & (result[7] != a[7]). The ALU overflow term is valid for addition only.
  - AND/OR/XOR: C = 0, V = 0. The ALU cout is stale for logic ops and must not be used.
- LDI (is_ldi=1):
  - WB writes reg[rd] = imm; flags unchanged; done = 1.
  - ALU outputs are still sequenced but their results are ignored.
  - is_ldi overrides alu_op decoding, so illegal never fires for LDI.
- Unsupported alu_op, non-LDI: no register write, flags unchanged, done = 1 and illegal = 1 in WB.
- Latency: accept edge at cycle 0; reg and flags visible after edge 3; done high during cycle 3 (WB). Throughput is one instruction per 4 cycles.
- rd == rs is legal; both operands read the same pre-write value.
- dbg_data reflects the post-write value from the cycle after the WB edge.
- Reset mid-operation aborts the instruction: no partial write, no done.

Optional Feature:
- Macro: ALU_EXEC_FAST_WB_EN.
- Defined:
  - EXEC and WB merge into one state: the result is sampled and written on the same edge.
  - States are IDLE, DECODE, EXEC; latency 2; done asserts during EXEC; throughput one instruction per 3 cycles.
- Undefined: the 4-state behaviour above.

Test Plan:
- Reset, then dbg_sel = 0..3 -> dbg_data = 8'h00; flags = 4'b0000; instr_ready = 1 after reset release.
- LDI r1,0x7F; LDI r2,0x01; ADD r1,r2 -> r1 = 8'h80; flags Z=0 N=1 C=0 V=1; done exactly 3 cycles after each accept.
- LDI r0,0x80; SUB r0,imm 0x01 -> r0 = 8'h7F; V = 1 (locally recomputed, not the ALU value); N=0, Z=0, C=1.
- LDI r3,0x0F; XOR r3,imm 0x0F -> r3 = 8'h00; Z=1, N=0, C=0, V=0 even when the prior ADD left cout=1.
- Unsupported alu_op with rd = r1 holding 8'h80 -> r1 unchanged, flags unchanged; illegal and done pulse together for 1 cycle.
- instr_valid held high through DECODE/EXEC -> no second accept until IDLE; assert rst_n=0 during EXEC -> no write, all regs = 8'h00.
